// File: rtl/booth_datapath_if.sv
// Command/status bundle between the Booth multiplier control FSM (master) and its datapath (slave).
interface booth_datapath_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [1:0]         q_mode;
  logic [1:0]         a_mode;
  logic               m_load;
  logic [1:0]         alu_op;
  logic               q0;
  logic               q_m1;
  logic               count_zero;
  logic [2*WIDTH-1:0] product;

  modport master (
    output multiplicand, multiplier, q_mode, a_mode, m_load, alu_op,
    input  q0, q_m1, count_zero, product
  );

  modport slave (
    input  multiplicand, multiplier, q_mode, a_mode, m_load, alu_op,
    output q0, q_m1, count_zero, product
  );
endinterface

// File: rtl/booth_datapath.sv
// Booth radix-2 multiplier datapath: M, A, Q, Q-1 and iteration counter driven by FSM commands.
module booth_datapath #(
  parameter int unsigned WIDTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  booth_datapath_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_res;

  // Sums wrap modulo 2^WIDTH; pass codes leave A unchanged.
  always_comb begin
    alu_res = a_q;
    unique case (bus.alu_op)
      2'b01:   alu_res = a_q + m_q;
      2'b10:   alu_res = a_q - m_q;
      default: alu_res = a_q;
    endcase
  end

  always_comb begin
    a_d = a_q;
    unique case (bus.a_mode)
      2'b00:   a_d = alu_res;
      2'b01:   a_d = a_q;
      2'b10:   a_d = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
      default: a_d = '0;
    endcase
  end

  // Shift pulls the pre-edge A[0] even when A is also being rewritten this edge.
  always_comb begin
    q_d   = q_q;
    qm1_d = qm1_q;
    unique case (bus.q_mode)
      2'b00: begin
        q_d   = q_q;
        qm1_d = qm1_q;
      end
      2'b01: begin
        q_d   = bus.multiplier;
        qm1_d = 1'b0;
      end
      2'b10: begin
        q_d   = {a_q[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
      end
      default: begin
        q_d   = '0;
        qm1_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    m_d   = bus.m_load ? bus.multiplicand : m_q;
    cnt_d = cnt_q;
    if (bus.m_load) begin
      cnt_d = CW'(WIDTH);
    end else if (bus.q_mode == 2'b10 && cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      qm1_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      m_q   <= m_d;
      qm1_q <= qm1_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.q0         = q_q[0];
  assign bus.q_m1       = qm1_q;
  assign bus.count_zero = (cnt_q == '0);
  assign bus.product    = {a_q, q_q};
endmodule

// File: tb/tb_booth_datapath.sv
// Scoreboard bench for booth_datapath (WIDTH=4): stimulus queues expectations, monitor checks them.
module tb_booth_datapath;
  logic clk;
  logic rst_n;

  booth_datapath_if #(.WIDTH(4)) bus ();

  booth_datapath #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [7:0] prod;
    logic       q0;
    logic       qm1;
    logic       cz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are register taps, sampled on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [10:0] act, req;
      e   = sb.pop_front();
      act = {bus.product, bus.q0, bus.q_m1, bus.count_zero};
      req = {e.prod, e.q0, e.qm1, e.cz};
      checks++;
      if (act !== req) begin
        errors++;
        $display("FAIL %s: got prod=%h q0=%b qm1=%b cz=%b, expected prod=%h q0=%b qm1=%b cz=%b",
                 e.name, act[10:3], act[2], act[1], act[0], req[10:3], req[2], req[1], req[0]);
      end
    end
  end

  task automatic push(input string nm, input logic [7:0] p, input logic q0, input logic qm1,
                      input logic cz);
    exp_t e;
    e.name = nm;
    e.prod = p;
    e.q0   = q0;
    e.qm1  = qm1;
    e.cz   = cz;
    sb.push_back(e);
  endtask

  task automatic idle();
    bus.q_mode = 2'b00;
    bus.a_mode = 2'b01;
    bus.m_load = 1'b0;
    bus.alu_op = 2'b00;
  endtask

  task automatic step(input logic [1:0] qm, input logic [1:0] am, input logic ml,
                      input logic [1:0] op);
    bus.q_mode = qm;
    bus.a_mode = am;
    bus.m_load = ml;
    bus.alu_op = op;
    @(posedge clk);
    #1;
    idle();
  endtask

  // Controller-style multiply; Booth pair derived from the bench's own copy of the multiplier.
  task automatic mul(input logic [3:0] mc, input logic [3:0] mp, input logic [7:0] exp_p,
                     input string nm);
    logic       prev;
    logic [1:0] op;
    prev = 1'b0;
    bus.multiplicand = mc;
    bus.multiplier   = mp;
    step(2'b01, 2'b11, 1'b1, 2'b00);
    for (int i = 0; i < 4; i++) begin
      if ({mp[i], prev} == 2'b10)      op = 2'b10;
      else if ({mp[i], prev} == 2'b01) op = 2'b01;
      else                             op = 2'b00;
      step(2'b00, 2'b00, 1'b0, op);
      step(2'b10, 2'b10, 1'b0, 2'b00);
      prev = mp[i];
    end
    push(nm, exp_p, exp_p[0], mp[3], 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    idle();
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    push("reset_release", 8'h00, 1'b0, 1'b0, 1'b1);

    mul(4'h3, 4'hE, 8'hFA, "mul_3_x_m2");
    mul(4'h7, 4'h7, 8'h31, "mul_7_x_7");
    mul(4'hD, 4'hD, 8'h09, "mul_m3_x_m3");
    mul(4'h0, 4'hB, 8'h00, "mul_0_x_m5");

    bus.multiplicand = 4'h3;
    bus.multiplier   = 4'b0101;
    step(2'b01, 2'b11, 1'b1, 2'b00);
    push("setup_bits", 8'h05, 1'b1, 1'b0, 1'b0);
    step(2'b10, 2'b10, 1'b0, 2'b00);
    push("first_shift", 8'h02, 1'b0, 1'b1, 1'b0);
    step(2'b10, 2'b00, 1'b0, 2'b10);
    push("sub_wrap_old_a0", 8'hD1, 1'b1, 1'b0, 1'b0);
    step(2'b10, 2'b01, 1'b1, 2'b00);
    push("load_beats_dec", 8'hD8, 1'b0, 1'b1, 1'b0);
    step(2'b10, 2'b10, 1'b0, 2'b00);
    step(2'b10, 2'b10, 1'b0, 2'b00);
    step(2'b10, 2'b10, 1'b0, 2'b00);
    push("shift3_cnt1", 8'hFB, 1'b1, 1'b0, 1'b0);
    step(2'b10, 2'b10, 1'b0, 2'b00);
    push("shift4_cnt0", 8'hFD, 1'b1, 1'b1, 1'b1);
    step(2'b10, 2'b10, 1'b0, 2'b00);
    push("shift5_saturate", 8'hFE, 1'b0, 1'b1, 1'b1);
    step(2'b11, 2'b11, 1'b0, 2'b00);
    push("clear_all", 8'h00, 1'b0, 1'b0, 1'b1);

    // Async reset mid-multiply: asserted and checked between clock edges.
    bus.multiplicand = 4'h7;
    bus.multiplier   = 4'h7;
    step(2'b01, 2'b11, 1'b1, 2'b00);
    step(2'b00, 2'b00, 1'b0, 2'b10);
    push("pre_async_reset", 8'h97, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    push("async_reset", 8'h00, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    push("post_reset_hold", 8'h00, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
